// File: rtl/step_burst_gate.sv
// step_burst_gate: on a start-key press, passes exactly N step strobes from the
// rate generator to the phase sequencer, then closes. N covers 1/4..1 revolution
// in full- or half-step mode. Provides abort, busy/done/aborted status and a
// remaining-step readout.
// Optional feature: define STEP_BURST_QUEUE_EN for a one-deep request queue.
module step_burst_gate #(
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned STEPS_PER_REV = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             start_key,
  input  logic             full_step,
  input  logic [1:0]       turn_sel,
  input  logic             abort,
  output logic             step_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             queued,
  output logic [CNT_W-1:0] steps_left
);

  localparam logic [CNT_W-1:0] QUARTER = CNT_W'(STEPS_PER_REV / 4);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] target, target_nx;
  logic [CNT_W-1:0] steps_left_nx;
  logic             start_q, start_rise, last_step;
  logic             done_nx, aborted_nx;

`ifdef STEP_BURST_QUEUE_EN
  logic       pend_valid, pend_valid_nx;
  logic       pend_full, pend_full_nx;
  logic [1:0] pend_turn, pend_turn_nx;
`endif

  // Burst length for a given mode/turn selection
  function automatic logic [CNT_W-1:0] calc_target(input logic fs, input logic [1:0] ts);
    logic [CNT_W-1:0] t;
    t = QUARTER * (CNT_W'(ts) + CNT_W'(1));
    return fs ? t : (t << 1);
  endfunction

  assign start_rise = start_key & ~start_q;
  assign last_step  = step_in && (count == target - CNT_W'(1));

  // Gated strobe: zero latency, closed outside RUN, during abort and in reset
  assign step_out = step_in & (state == RUN) & ~abort & ~rst;

  // Next-state, counter and status pulse logic
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    target_nx  = target;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;
`ifdef STEP_BURST_QUEUE_EN
    pend_valid_nx = pend_valid;
    pend_full_nx  = pend_full;
    pend_turn_nx  = pend_turn;
`endif
    case (state)
      IDLE: begin
        if (start_rise && !abort) begin
          state_nx  = RUN;
          target_nx = calc_target(full_step, turn_sel);
          count_nx  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx   = IDLE;
          count_nx   = '0;
          aborted_nx = 1'b1;
`ifdef STEP_BURST_QUEUE_EN
          pend_valid_nx = 1'b0;
`endif
        end else begin
          if (last_step) begin
            count_nx = '0;
            done_nx  = 1'b1;
            state_nx = IDLE;
`ifdef STEP_BURST_QUEUE_EN
            // Chain straight into the next burst: pending request first,
            // otherwise a press landing on the final step
            if (pend_valid) begin
              state_nx      = RUN;
              target_nx     = calc_target(pend_full, pend_turn);
              pend_valid_nx = 1'b0;
            end else if (start_rise) begin
              state_nx  = RUN;
              target_nx = calc_target(full_step, turn_sel);
            end
`endif
          end else if (step_in) begin
            count_nx = count + CNT_W'(1);
          end
`ifdef STEP_BURST_QUEUE_EN
          // Hold one request; later presses are dropped
          if (start_rise && !pend_valid && !last_step) begin
            pend_valid_nx = 1'b1;
            pend_full_nx  = full_step;
            pend_turn_nx  = turn_sel;
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
    steps_left_nx = (state_nx == RUN) ? (target_nx - count_nx) : '0;
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      target     <= '0;
      start_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      target     <= target_nx;
      start_q    <= start_key;
      busy       <= (state_nx == RUN);
      done       <= done_nx;
      aborted    <= aborted_nx;
      steps_left <= steps_left_nx;
    end
  end

`ifdef STEP_BURST_QUEUE_EN
  // Pending request storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_full  <= 1'b0;
      pend_turn  <= 2'b00;
    end else begin
      pend_valid <= pend_valid_nx;
      pend_full  <= pend_full_nx;
      pend_turn  <= pend_turn_nx;
    end
  end

  assign queued = pend_valid;
`else
  assign queued = 1'b0;
`endif

endmodule

// File: tb/tb_step_burst_gate.sv
// Testbench for step_burst_gate: a behavioural model (remaining-step count plus
// a request queue) checked against the DUT every cycle, plus literal expectations.
module tb_step_burst_gate;

  localparam int unsigned CNT_W = 10;
  localparam int SPR = 200;
`ifdef STEP_BURST_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             step_in = 1'b0;
  logic             start_key = 1'b0;
  logic             full_step = 1'b1;
  logic [1:0]       turn_sel = 2'b00;
  logic             abort = 1'b0;
  logic             step_out, busy, done, aborted, queued;
  logic [CNT_W-1:0] steps_left;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int dones = 0;
  int aborts = 0;

  step_burst_gate #(.CNT_W(CNT_W), .STEPS_PER_REV(SPR)) dut (
    .clk(clk), .rst(rst), .step_in(step_in), .start_key(start_key),
    .full_step(full_step), .turn_sel(turn_sel), .abort(abort),
    .step_out(step_out), .busy(busy), .done(done), .aborted(aborted),
    .queued(queued), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  // Behavioural model: a burst is "remaining steps"; requests are a queue of lengths
  bit m_busy, m_done, m_abt, m_key_q;
  int m_left;
  int m_q[$];

  function automatic int burst_len(input bit f, input int t);
    return (SPR / 4) * (t + 1) * (f ? 1 : 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_abt = 0; m_key_q = 0; m_left = 0;
      m_q.delete();
    end else begin
      bit rise, fin;
      rise = start_key && !m_key_q;
      m_key_q = start_key;
      m_done = 0;
      m_abt = 0;
      if (m_busy) begin
        if (abort) begin
          m_busy = 0; m_left = 0; m_abt = 1;
          m_q.delete();
        end else begin
          fin = step_in && (m_left == 1);
          if (step_in) m_left--;
          if (fin) begin
            m_done = 1;
            if (QEN && m_q.size() > 0) m_left = m_q.pop_front();
            else if (QEN && rise) m_left = burst_len(full_step, int'(turn_sel));
            else m_busy = 0;
          end else if (QEN && rise && m_q.size() == 0) begin
            m_q.push_back(burst_len(full_step, int'(turn_sel)));
          end
        end
      end else if (rise && !abort) begin
        m_busy = 1;
        m_left = burst_len(full_step, int'(turn_sel));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against model on the falling edge, tally pulses, then move to posedge+1
  task automatic tick();
    @(negedge clk);
    chk("step_out", int'(step_out), int'(step_in && m_busy && !abort && !rst));
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("aborted", int'(aborted), int'(m_abt));
    chk("queued", int'(queued), int'(m_q.size() != 0));
    chk("steps_left", int'(steps_left), m_left);
    if (step_out) pulses++;
    if (done) dones++;
    if (aborted) aborts++;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit f, input logic [1:0] t);
    full_step = f; turn_sel = t; start_key = 1'b1;
    tick();
  endtask

  task automatic release_key();
    start_key = 1'b0;
    tick();
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      step_in = 1'b1; tick();
      step_in = 1'b0; tick();
    end
  endtask

  int p0, d0, a0;

  initial begin
    @(posedge clk); #1;
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_steps_left", int'(steps_left), 0);
    rst = 1'b0;
    tick();

    // 1: quarter turn, full step -> 50 pulses, one done
    p0 = pulses; d0 = dones;
    press(1'b1, 2'b00);
    chk("t1_busy", int'(busy), 1);
    chk("t1_left_start", int'(steps_left), 50);
    release_key();
    strobes(60);
    chk("t1_pulses", pulses - p0, 50);
    chk("t1_dones", dones - d0, 1);
    chk("t1_busy_end", int'(busy), 0);

    // 2: full revolution, half step -> 400 pulses
    p0 = pulses; d0 = dones;
    press(1'b0, 2'b11);
    chk("t2_left_start", int'(steps_left), 400);
    release_key();
    strobes(410);
    chk("t2_pulses", pulses - p0, 400);
    chk("t2_dones", dones - d0, 1);
    chk("t2_left_end", int'(steps_left), 0);

    // 3: abort on the 20th strobe
    p0 = pulses; d0 = dones; a0 = aborts;
    press(1'b1, 2'b00);
    release_key();
    strobes(19);
    chk("t3_left_19", int'(steps_left), 31);
    step_in = 1'b1; abort = 1'b1;
    tick();
    chk("t3_aborted", int'(aborted), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_left", int'(steps_left), 0);
    step_in = 1'b0; abort = 1'b0;
    tick();
    chk("t3_pulses", pulses - p0, 19);
    chk("t3_dones", dones - d0, 0);
    chk("t3_aborts", aborts - a0, 1);

    // Press while abort held in IDLE is ignored
    abort = 1'b1;
    press(1'b1, 2'b00);
    chk("abort_idle_busy", int'(busy), 0);
    abort = 1'b0;
    release_key();
    chk("abort_idle_busy2", int'(busy), 0);

    // 4: reset mid-burst
    press(1'b1, 2'b00);
    release_key();
    strobes(10);
    step_in = 1'b1; rst = 1'b1;
    #1;
    chk("t4_step_out", int'(step_out), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_left", int'(steps_left), 0);
    tick();
    step_in = 1'b0; rst = 1'b0;
    tick();
    p0 = pulses; d0 = dones;
    press(1'b1, 2'b00);
    release_key();
    strobes(60);
    chk("t4_pulses", pulses - p0, 50);
    chk("t4_dones", dones - d0, 1);

    if (QEN) begin
      // 5: queued second request runs back to back; third press dropped
      p0 = pulses; d0 = dones;
      press(1'b1, 2'b00);
      release_key();
      strobes(5);
      press(1'b0, 2'b01);
      chk("t5_queued", int'(queued), 1);
      release_key();
      press(1'b1, 2'b11);
      release_key();
      strobes(300);
      chk("t5_pulses", pulses - p0, 250);
      chk("t5_dones", dones - d0, 2);
      chk("t5_queued_end", int'(queued), 0);
      chk("t5_busy_end", int'(busy), 0);
    end else begin
      // 6: second press ignored; held key does not retrigger
      p0 = pulses; d0 = dones;
      press(1'b1, 2'b00);
      release_key();
      strobes(5);
      press(1'b0, 2'b11);
      chk("t6_queued", int'(queued), 0);
      strobes(60);
      chk("t6_pulses", pulses - p0, 50);
      chk("t6_dones", dones - d0, 1);
      chk("t6_busy_end", int'(busy), 0);
      release_key();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
